// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: command codes and classifier states shared by the stopwatch path.
package stopwatch_pkg;

    typedef enum logic [3:0] {
        CMD_NONE                 = 4'd0,
        CMD_STOP_EDITMODE_TOGGLE = 4'd1,
        CMD_STOP_EDITDIGIT_NEXT  = 4'd2,
        CMD_STOP_CLEAR           = 4'd3,
        CMD_STOP_DIGIT_UP        = 4'd4,
        CMD_STOP_DIGIT_DOWN      = 4'd5
    } cmd_e;

    typedef enum logic [1:0] {
        ST_WAIT_RELEASE,
        ST_IDLE,
        ST_PRESS
    } press_state_e;

    // Bit order {down, up, clear, digit_next, editmode_toggle}.
    function automatic logic [4:0] cmd_onehot(cmd_e c);
        return {c == CMD_STOP_DIGIT_DOWN, c == CMD_STOP_DIGIT_UP, c == CMD_STOP_CLEAR,
                c == CMD_STOP_EDITDIGIT_NEXT, c == CMD_STOP_EDITMODE_TOGGLE};
    endfunction

endpackage

// File: rtl/input_distributor_if.sv
// input_distributor_if: debounced buttons and gating inputs in, command strobes out.
interface input_distributor_if;
    logic       iBtnC;
    logic       iBtnL;
    logic       iBtnU;
    logic       iBtnD;
    logic       iModeSel;
    logic       iEditEn;
    logic       oCmdValid;
    logic [3:0] oCmdCode;
    logic       oEditModeToggle;
    logic       oEditDigitNext;
    logic       oClear;
    logic       oDigitUp;
    logic       oDigitDown;

    modport master (
        output iBtnC, iBtnL, iBtnU, iBtnD, iModeSel, iEditEn,
        input  oCmdValid, oCmdCode, oEditModeToggle, oEditDigitNext, oClear, oDigitUp, oDigitDown
    );

    modport slave (
        input  iBtnC, iBtnL, iBtnU, iBtnD, iModeSel, iEditEn,
        output oCmdValid, oCmdCode, oEditModeToggle, oEditDigitNext, oClear, oDigitUp, oDigitDown
    );
endinterface

// File: rtl/btn_press_classifier.sv
// btn_press_classifier: splits a held button into one-cycle short/long press events.
module btn_press_classifier
    import stopwatch_pkg::*;
#(
    parameter int LONG_PRESS_CYC = 100_000_000
) (
    input  logic iClk,
    input  logic iRstn,
    input  logic iBtn,
    output logic oShort,
    output logic oLong
);
    localparam int CW = $clog2(LONG_PRESS_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LONG_PRESS_CYC);

    press_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= ST_WAIT_RELEASE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = (state_q == ST_WAIT_RELEASE) ? (iBtn ? ST_WAIT_RELEASE : ST_IDLE)
                : (state_q == ST_IDLE)         ? (iBtn ? ST_PRESS : ST_IDLE)
                : !iBtn                        ? ST_IDLE
                : (cnt_inc == CNT_MAX)         ? ST_WAIT_RELEASE
                :                                ST_PRESS;
        cnt_d   = (state_q == ST_IDLE)          ? (iBtn ? CW'(1) : cnt_q)
                : (state_q == ST_PRESS && iBtn) ? cnt_inc
                :                                 cnt_q;
    end

    always_comb begin
        oLong  = (state_q == ST_PRESS) && iBtn && (cnt_inc == CNT_MAX);
        oShort = (state_q == ST_PRESS) && !iBtn && (cnt_q < CNT_MAX);
    end
endmodule

// File: rtl/input_distributor.sv
// input_distributor: turns debounced button levels into gated, prioritised one-cycle
// stopwatch commands.
module input_distributor
    import stopwatch_pkg::*;
#(
    parameter int LONG_PRESS_CYC = 100_000_000
) (
    input  logic                iClk,
    input  logic                iRstn,
    input_distributor_if.slave  bus
);
    logic       c_short, c_long;
    logic       l_ev, u_ev, d_ev;
    logic [2:0] lud_q, lud_d;
    cmd_e       cmd_q, cmd_d;

    btn_press_classifier #(.LONG_PRESS_CYC(LONG_PRESS_CYC)) u_btn_c (
        .iClk   (iClk),
        .iRstn  (iRstn),
        .iBtn   (bus.iBtnC),
        .oShort (c_short),
        .oLong  (c_long)
    );

    // Gates are applied before priority, so a gated-off event never masks a lower one.
    always_comb begin
        lud_d           = {bus.iBtnL, bus.iBtnU, bus.iBtnD};
        {l_ev, u_ev, d_ev} = lud_d & ~lud_q;
        cmd_d = bus.iModeSel                ? CMD_NONE
              : c_long                      ? CMD_STOP_EDITMODE_TOGGLE
              : (c_short && bus.iEditEn)    ? CMD_STOP_EDITDIGIT_NEXT
              : (l_ev && !bus.iEditEn)      ? CMD_STOP_CLEAR
              : (u_ev && bus.iEditEn)       ? CMD_STOP_DIGIT_UP
              : (d_ev && bus.iEditEn)       ? CMD_STOP_DIGIT_DOWN
              :                               CMD_NONE;
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            lud_q <= 3'b111;
            cmd_q <= CMD_NONE;
        end else begin
            lud_q <= lud_d;
            cmd_q <= cmd_d;
        end
    end

    assign bus.oCmdValid = (cmd_q != CMD_NONE);
    assign bus.oCmdCode  = cmd_q;
    assign {bus.oDigitDown, bus.oDigitUp, bus.oClear, bus.oEditDigitNext, bus.oEditModeToggle} =
        cmd_onehot(cmd_q);
endmodule

// File: tb/tb_input_distributor.sv
// tb_input_distributor: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_input_distributor;
    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pe = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    input_distributor_if bus();

    input_distributor #(.LONG_PRESS_CYC(8)) dut (
        .iClk  (clk),
        .iRstn (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pe <= pe + 1;

    function automatic logic [4:0] pulses();
        return {bus.oDigitDown, bus.oDigitUp, bus.oClear, bus.oEditDigitNext, bus.oEditModeToggle};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.oCmdValid) begin
                logic [4:0] want;
                want = (bus.oCmdCode >= 4'd1 && bus.oCmdCode <= 4'd5) ? 5'(5'b1 << (bus.oCmdCode - 4'd1)) : 5'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cmd: got code %0d at edge %0d, required no command", bus.oCmdCode, pe);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.oCmdCode != e.code || pe != e.cyc) begin
                        errors++;
                        $display("FAIL cmd: got code %0d at edge %0d, required code %0d at edge %0d", bus.oCmdCode, pe, e.code, e.cyc);
                    end
                end
                checks++;
                if (pulses() != want || want == 5'b0) begin
                    errors++;
                    $display("FAIL pulses: got %b for code %0d, required %b", pulses(), bus.oCmdCode, want);
                end
            end else begin
                checks++;
                if (bus.oCmdCode != 4'd0 || pulses() != 5'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: got code %0d pulses %b at edge %0d, required 0/00000", bus.oCmdCode, pulses(), pe);
                end
            end
        end
    end

    task automatic chk_idle(input string name);
        checks++;
        if (bus.oCmdValid || bus.oCmdCode != 4'd0 || pulses() != 5'b0) begin
            errors++;
            $display("FAIL %s: got valid %b code %0d pulses %b, required all 0", name, bus.oCmdValid, bus.oCmdCode, pulses());
        end
    endtask

    task automatic press(input logic [2:0] lud, input logic [3:0] exp);
        {bus.iBtnL, bus.iBtnU, bus.iBtnD} = lud;
        if (exp != 4'd0) exp_q.push_back('{exp, pe + 1});
        @(negedge clk);
        {bus.iBtnL, bus.iBtnU, bus.iBtnD} = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic hold_c(input int n, input logic [3:0] exp_long, input logic [3:0] exp_short);
        bus.iBtnC = 1'b1;
        if (exp_long != 4'd0) exp_q.push_back('{exp_long, pe + 8});
        repeat (n) @(negedge clk);
        bus.iBtnC = 1'b0;
        if (exp_short != 4'd0) exp_q.push_back('{exp_short, pe + 1});
        repeat (3) @(negedge clk);
    endtask

    initial begin
        {bus.iBtnC, bus.iBtnL, bus.iBtnD, bus.iModeSel} = 4'b0000;
        bus.iBtnU   = 1'b1;
        bus.iEditEn = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset_state");
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        bus.iBtnU = 1'b0;
        repeat (5) @(negedge clk);
        press(3'b010, 4'd4);

        bus.iEditEn = 1'b0;
        hold_c(10, 4'd1, 4'd0);
        bus.iEditEn = 1'b1;
        hold_c(3, 4'd0, 4'd2);
        bus.iEditEn = 1'b0;
        hold_c(3, 4'd0, 4'd0);

        press(3'b100, 4'd3);
        press(3'b010, 4'd0);
        press(3'b001, 4'd0);
        bus.iEditEn = 1'b1;
        press(3'b100, 4'd0);
        press(3'b010, 4'd4);
        press(3'b001, 4'd5);

        bus.iEditEn = 1'b0;
        press(3'b111, 4'd3);
        bus.iEditEn = 1'b1;
        press(3'b111, 4'd4);
        bus.iBtnC = 1'b1;
        exp_q.push_back('{4'd1, pe + 8});
        repeat (7) @(negedge clk);
        bus.iBtnU = 1'b1;
        @(negedge clk);
        bus.iBtnU = 1'b0;
        repeat (3) @(negedge clk);
        bus.iBtnC = 1'b0;
        repeat (3) @(negedge clk);

        bus.iModeSel = 1'b1;
        for (int e = 0; e < 2; e++) begin
            bus.iEditEn = e[0];
            press(3'b100, 4'd0);
            press(3'b010, 4'd0);
            press(3'b001, 4'd0);
            press(3'b111, 4'd0);
            hold_c(10, 4'd0, 4'd0);
            hold_c(3, 4'd0, 4'd0);
        end
        bus.iBtnC = 1'b1;
        exp_q.push_back('{4'd1, pe + 8});
        repeat (3) @(negedge clk);
        bus.iModeSel = 1'b0;
        repeat (7) @(negedge clk);
        bus.iBtnC = 1'b0;
        repeat (3) @(negedge clk);

        bus.iEditEn = 1'b1;
        bus.iBtnC = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle("reset_mid_hold");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        bus.iBtnC = 1'b0;
        repeat (3) @(negedge clk);
        hold_c(3, 4'd0, 4'd2);
        hold_c(10, 4'd1, 4'd0);

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect: got %0d commands still pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
